// File: rtl/food_placer.sv
// -----------------------------------------------------------------------------
// food_placer
//
// Turns the free-running random word into a legal food cell on the snake grid.
// Random candidates that fall off the grid or land on an occupied cell are
// rejected. After MAX_TRIES rejected draws the block abandons random placement
// and scans the grid row-major for the first free cell. If no cell is free, it
// reports failure instead.
//
// Ports
//   clk         system clock, all state on the rising edge
//   reset       asynchronous, active-high; aborts any placement, returns to IDLE
//   random      random word, candidate x in [XW-1:0], y in [XW+YW-1:XW]
//   place_req   request a new food cell, honoured only while idle
//   occ_rd      occupancy RAM read strobe (combinational from state)
//   occ_x/occ_y occupancy RAM read address (don't-care while occ_rd is low)
//   occ_data    occupancy RAM read data, valid the cycle after occ_rd
//   busy        high whenever a placement is in progress
//   food_x/y    last placed cell, held until the next successful placement
//   food_valid  one-cycle pulse, food_x/food_y updated on the same edge
//   fail        one-cycle pulse, the grid has no free cell
// -----------------------------------------------------------------------------
module food_placer #(
    parameter int COLS      = 20,
    parameter int ROWS      = 15,
    parameter int RAND_W    = 10,
    parameter int MAX_TRIES = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [RAND_W-1:0]         random,
    input  logic                      place_req,
    output logic                      occ_rd,
    output logic [$clog2(COLS)-1:0]   occ_x,
    output logic [$clog2(ROWS)-1:0]   occ_y,
    input  logic                      occ_data,
    output logic                      busy,
    output logic [$clog2(COLS)-1:0]   food_x,
    output logic [$clog2(ROWS)-1:0]   food_y,
    output logic                      food_valid,
    output logic                      fail
);

    localparam int XW = $clog2(COLS);
    localparam int YW = $clog2(ROWS);
    localparam int TW = $clog2(MAX_TRIES + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SAMPLE   = 3'd1,
        CHECK    = 3'd2,
        SCAN_RD  = 3'd3,
        SCAN_CHK = 3'd4
    } state_t;

    state_t          state_r;
    state_t          state_s;

    logic [TW-1:0]   tries_r;
    logic [XW-1:0]   cand_x_r;
    logic [YW-1:0]   cand_y_r;
    logic [XW-1:0]   ptr_x_r;
    logic [YW-1:0]   ptr_y_r;
    logic [XW-1:0]   food_x_r;
    logic [YW-1:0]   food_y_r;
    logic            food_valid_r;
    logic            fail_r;

    logic [XW-1:0]   cx_s;
    logic [YW-1:0]   cy_s;
    logic            on_grid_s;
    logic            tries_done_s;
    logic            ptr_last_s;
    logic            rand_unused_s;

    // Datapath strobes decoded by the FSM
    logic            tries_clr_s;
    logic            tries_inc_s;
    logic            cand_ld_s;
    logic            ptr_clr_s;
    logic            ptr_adv_s;
    logic            food_ld_cand_s;
    logic            food_ld_ptr_s;
    logic            fail_set_s;

    // Candidate extraction; random bits above XW+YW do not influence placement
    assign cx_s          = random[XW-1:0];
    assign cy_s          = random[XW+YW-1:XW];
    assign rand_unused_s = ^random;

    // Comparisons are done at integer width so a power-of-two grid dimension
    // cannot alias to zero in the narrow coordinate width.
    assign on_grid_s    = (int'(cx_s) < COLS) && (int'(cy_s) < ROWS);
    assign tries_done_s = (int'(tries_r) == MAX_TRIES);
    assign ptr_last_s   = (int'(ptr_x_r) == COLS - 1) && (int'(ptr_y_r) == ROWS - 1);

    assign busy       = (state_r != IDLE);
    assign food_x     = food_x_r;
    assign food_y     = food_y_r;
    assign food_valid = food_valid_r;
    assign fail       = fail_r;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state, occupancy read port and datapath strobes
    always_comb begin
        state_s        = state_r;
        occ_rd         = 1'b0;
        occ_x          = '0;
        occ_y          = '0;
        tries_clr_s    = 1'b0;
        tries_inc_s    = 1'b0;
        cand_ld_s      = 1'b0;
        ptr_clr_s      = 1'b0;
        ptr_adv_s      = 1'b0;
        food_ld_cand_s = 1'b0;
        food_ld_ptr_s  = 1'b0;
        fail_set_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (place_req) begin
                    tries_clr_s = 1'b1;
                    state_s     = SAMPLE;
                end else begin
                    state_s = IDLE;
                end
            end
            SAMPLE: begin
                if (tries_done_s) begin
                    ptr_clr_s = 1'b1;
                    state_s   = SCAN_RD;
                end else if (!on_grid_s) begin
                    // Off-grid draw: count it and take a fresh word next cycle
                    tries_inc_s = 1'b1;
                    state_s     = SAMPLE;
                end else begin
                    occ_rd    = 1'b1;
                    occ_x     = cx_s;
                    occ_y     = cy_s;
                    cand_ld_s = 1'b1;
                    state_s   = CHECK;
                end
            end
            CHECK: begin
                if (!occ_data) begin
                    food_ld_cand_s = 1'b1;
                    state_s        = IDLE;
                end else begin
                    tries_inc_s = 1'b1;
                    state_s     = SAMPLE;
                end
            end
            SCAN_RD: begin
                occ_rd  = 1'b1;
                occ_x   = ptr_x_r;
                occ_y   = ptr_y_r;
                state_s = SCAN_CHK;
            end
            SCAN_CHK: begin
                if (!occ_data) begin
                    food_ld_ptr_s = 1'b1;
                    state_s       = IDLE;
                end else if (ptr_last_s) begin
                    fail_set_s = 1'b1;
                    state_s    = IDLE;
                end else begin
                    ptr_adv_s = 1'b1;
                    state_s   = SCAN_RD;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Draw counter and latched random candidate
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tries_r  <= '0;
            cand_x_r <= '0;
            cand_y_r <= '0;
        end else begin
            if (tries_clr_s) begin
                tries_r <= '0;
            end else if (tries_inc_s) begin
                tries_r <= tries_r + TW'(1);
            end else begin
                tries_r <= tries_r;
            end
            if (cand_ld_s) begin
                cand_x_r <= cx_s;
                cand_y_r <= cy_s;
            end else begin
                cand_x_r <= cand_x_r;
                cand_y_r <= cand_y_r;
            end
        end
    end

    // Row-major scan pointer; x wraps to 0 and y steps at the end of each row
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_x_r <= '0;
            ptr_y_r <= '0;
        end else if (ptr_clr_s) begin
            ptr_x_r <= '0;
            ptr_y_r <= '0;
        end else if (ptr_adv_s) begin
            if (int'(ptr_x_r) == COLS - 1) begin
                ptr_x_r <= '0;
                ptr_y_r <= ptr_y_r + YW'(1);
            end else begin
                ptr_x_r <= ptr_x_r + XW'(1);
                ptr_y_r <= ptr_y_r;
            end
        end else begin
            ptr_x_r <= ptr_x_r;
            ptr_y_r <= ptr_y_r;
        end
    end

    // Registered result: food cell plus the one-cycle success / fail pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            food_x_r     <= '0;
            food_y_r     <= '0;
            food_valid_r <= 1'b0;
            fail_r       <= 1'b0;
        end else begin
            if (food_ld_cand_s) begin
                food_x_r <= cand_x_r;
                food_y_r <= cand_y_r;
            end else if (food_ld_ptr_s) begin
                food_x_r <= ptr_x_r;
                food_y_r <= ptr_y_r;
            end else begin
                food_x_r <= food_x_r;
                food_y_r <= food_y_r;
            end
            food_valid_r <= food_ld_cand_s | food_ld_ptr_s;
            fail_r       <= fail_set_s;
        end
    end

endmodule

// File: tb/tb_food_placer.sv
// -----------------------------------------------------------------------------
// tb_food_placer
//
// Directed bench for food_placer with default parameters (20x15 grid, 10-bit
// random word, 32 draws). A small synchronous occupancy RAM model answers the
// DUT's reads one cycle after occ_rd. Inputs change on the falling edge and
// outputs are sampled there too. Cycle k is the period after rising edge k-1,
// where edge 0 is the edge that samples place_req.
// -----------------------------------------------------------------------------
module tb_food_placer;

    logic       clk;
    logic       reset;
    logic [9:0] random;
    logic       place_req;
    logic       occ_rd;
    logic [4:0] occ_x;
    logic [3:0] occ_y;
    logic       occ_data;
    logic       busy;
    logic [4:0] food_x;
    logic [3:0] food_y;
    logic       food_valid;
    logic       fail;

    int checks;
    int failures;

    // Occupancy RAM model, indexed [x][y]
    logic occ_mem [0:31][0:15];

    // Per-request observations collected by run_request
    logic [9:0] rand_seq [0:7];
    int         rand_len;
    int         fv_count;
    int         fv_first;
    int         fail_count;
    int         fail_first;
    int         both_seen;
    logic       busy_at_fv;
    logic       last_busy;

    food_placer dut (
        .clk        (clk),
        .reset      (reset),
        .random     (random),
        .place_req  (place_req),
        .occ_rd     (occ_rd),
        .occ_x      (occ_x),
        .occ_y      (occ_y),
        .occ_data   (occ_data),
        .busy       (busy),
        .food_x     (food_x),
        .food_y     (food_y),
        .food_valid (food_valid),
        .fail       (fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAM: data appears the cycle after the strobe
    always @(posedge clk) begin
        if (occ_rd) begin
            occ_data <= occ_mem[occ_x][occ_y];
        end
    end

    task automatic fill_mem(input logic v);
        for (int x = 0; x < 32; x++) begin
            for (int y = 0; y < 16; y++) begin
                occ_mem[x][y] = v;
            end
        end
    endtask

    // Issues one request and watches `limit` cycles; place_req is re-pulsed
    // in cycle poke_at (0 = never) to exercise the busy-ignore rule.
    task automatic run_request(input int limit, input int poke_at);
        fv_count   = 0;
        fv_first   = -1;
        fail_count = 0;
        fail_first = -1;
        both_seen  = 0;
        busy_at_fv = 1'bx;
        last_busy  = 1'bx;
        @(negedge clk);
        random    = rand_seq[0];
        place_req = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            if (food_valid) begin
                fv_count++;
                if (fv_first < 0) begin
                    fv_first   = k;
                    busy_at_fv = busy;
                end
            end
            if (fail) begin
                fail_count++;
                if (fail_first < 0) fail_first = k;
            end
            if (food_valid && fail) both_seen++;
            last_busy = busy;
            random    = (k - 1 < rand_len) ? rand_seq[k-1] : rand_seq[rand_len-1];
            place_req = (k == poke_at);
        end
        place_req = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || food_valid !== 1'b0 || fail !== 1'b0 || occ_rd !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: busy=%b food_valid=%b fail=%b occ_rd=%b, required all 0",
                     busy, food_valid, fail, occ_rd);
        end
        checks++;
        if (food_x !== 5'd0 || food_y !== 4'd0) begin
            failures++;
            $display("FAIL reset_food: got (%0d,%0d), required (0,0)", food_x, food_y);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || occ_rd !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: busy=%b occ_rd=%b, required 0 0", busy, occ_rd);
        end
    endtask

    task automatic test_basic;
        fill_mem(1'b0);
        rand_seq[0] = 10'h047;
        rand_len    = 1;
        run_request(8, 0);
        checks++;
        if (fv_first !== 3 || fv_count !== 1) begin
            failures++;
            $display("FAIL basic_latency: food_valid first cycle %0d count %0d, required 3 and 1",
                     fv_first, fv_count);
        end
        checks++;
        if (food_x !== 5'd7 || food_y !== 4'd2) begin
            failures++;
            $display("FAIL basic_food: got (%0d,%0d), required (7,2)", food_x, food_y);
        end
        checks++;
        if (busy_at_fv !== 1'b0 || fail_count !== 0) begin
            failures++;
            $display("FAIL basic_busy: busy at pulse %b fail pulses %0d, required 0 and 0",
                     busy_at_fv, fail_count);
        end
    endtask

    task automatic test_offgrid_reject;
        fill_mem(1'b0);
        rand_seq[0] = 10'h039;
        rand_seq[1] = 10'h1E0;
        rand_seq[2] = 10'h047;
        rand_len    = 3;
        run_request(10, 0);
        checks++;
        if (fv_first !== 5 || fv_count !== 1) begin
            failures++;
            $display("FAIL offgrid_latency: food_valid first cycle %0d count %0d, required 5 and 1",
                     fv_first, fv_count);
        end
        checks++;
        if (food_x !== 5'd7 || food_y !== 4'd2) begin
            failures++;
            $display("FAIL offgrid_food: got (%0d,%0d), required (7,2)", food_x, food_y);
        end
    endtask

    task automatic test_occupied_retry;
        fill_mem(1'b0);
        occ_mem[7][2] = 1'b1;
        rand_seq[0]   = 10'h047;
        rand_seq[1]   = 10'h024;
        rand_len      = 2;
        run_request(10, 0);
        checks++;
        if (food_x !== 5'd4 || food_y !== 4'd1) begin
            failures++;
            $display("FAIL retry_food: got (%0d,%0d), required (4,1)", food_x, food_y);
        end
        checks++;
        if (fv_first !== 5 || fv_count !== 1 || fail_count !== 0) begin
            failures++;
            $display("FAIL retry_latency: food_valid cycle %0d count %0d fail %0d, required 5 1 0",
                     fv_first, fv_count, fail_count);
        end
    endtask

    task automatic test_scan_fallback;
        fill_mem(1'b1);
        occ_mem[3][0] = 1'b0;
        rand_seq[0]   = 10'h039;
        rand_len      = 1;
        run_request(60, 0);
        checks++;
        if (food_x !== 5'd3 || food_y !== 4'd0) begin
            failures++;
            $display("FAIL scan_food: got (%0d,%0d), required (3,0)", food_x, food_y);
        end
        checks++;
        if (fv_first !== 42 || fv_count !== 1 || fail_count !== 0) begin
            failures++;
            $display("FAIL scan_latency: food_valid cycle %0d count %0d fail %0d, required 42 1 0",
                     fv_first, fv_count, fail_count);
        end
    endtask

    task automatic test_grid_full;
        fill_mem(1'b1);
        rand_seq[0] = 10'h039;
        rand_len    = 1;
        run_request(650, 100);
        checks++;
        if (fail_first !== 634 || fail_count !== 1) begin
            failures++;
            $display("FAIL full_fail: fail first cycle %0d count %0d, required 634 and 1",
                     fail_first, fail_count);
        end
        checks++;
        if (fv_count !== 0 || both_seen !== 0) begin
            failures++;
            $display("FAIL full_no_food: food_valid pulses %0d overlaps %0d, required 0 0",
                     fv_count, both_seen);
        end
        checks++;
        if (food_x !== 5'd3 || food_y !== 4'd0) begin
            failures++;
            $display("FAIL full_food_hold: got (%0d,%0d), required (3,0)", food_x, food_y);
        end
        checks++;
        if (last_busy !== 1'b0) begin
            failures++;
            $display("FAIL full_busy_ignore: busy=%b at end, required 0", last_busy);
        end
    endtask

    task automatic test_reset_mid_sample;
        fill_mem(1'b0);
        @(negedge clk);
        random    = 10'h039;
        place_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        place_req = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_busy: busy=%b before reset, required 1", busy);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || food_valid !== 1'b0 || fail !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_async: busy=%b food_valid=%b fail=%b, required 0 0 0",
                     busy, food_valid, fail);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || food_valid !== 1'b0 || fail !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_ctrl: busy=%b food_valid=%b fail=%b, required 0 0 0",
                     busy, food_valid, fail);
        end
        checks++;
        if (food_x !== 5'd0 || food_y !== 4'd0) begin
            failures++;
            $display("FAIL mid_reset_food: got (%0d,%0d), required (0,0)", food_x, food_y);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        random    = 10'h000;
        place_req = 1'b0;
        occ_data  = 1'b0;
        fill_mem(1'b0);
        test_reset;
        test_basic;
        test_offgrid_reject;
        test_occupied_retry;
        test_scan_fallback;
        test_grid_full;
        test_reset_mid_sample;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
